// File: rtl/fp_add_arbiter.sv
// Purpose: round-robin issue of tagged FP add/sub ops from NUM_REQ requesters into one shared,
//          non-stallable adder, with returning results steered into per-requester result FIFOs.
// Latency: grant is combinational; issue registered (+1 cycle); result visible in FIFO 1 cycle after res_valid.
// Backpressure: per-requester credits (FIFO free slots minus in-flight ops) gate grants, so the adder is never stalled.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         per-requester op handshake (req_ready one-hot or zero)
//   req_a/req_b/req_op          packed per-requester operands, slice [i*W +: W]
//   add_valid/a/b/op/tag        registered issue to the adder
//   res_valid/res_tag/res_data  adder result return
//   rsp_valid/rsp_data/rsp_ready per-requester result FIFO head and pop
//   inflight                    ops issued and not yet returned
//   err                         sticky protocol error

`ifndef FP16
`define FP16 0
`endif
`ifndef FP32
`define FP32 1
`endif
`ifndef FP64
`define FP64 2
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN ((data_format == `FP64) ? 11 : (data_format == `FP16) ? 5 : 8)
`endif
`ifndef GET_MANTISSA_LEN
`define GET_MANTISSA_LEN ((data_format == `FP64) ? 52 : (data_format == `FP16) ? 10 : 23)
`endif
`ifndef ADD
`define ADD 1'b0
`endif
`ifndef SUB
`define SUB 1'b1
`endif

module fp_add_arbiter #(
    parameter int data_format = `FP32,
    parameter int NUM_REQ     = 4,
    parameter int RSP_DEPTH   = 4,
    parameter int TAG_W       = $clog2(NUM_REQ),
    localparam int W          = `GET_EXP_LEN + `GET_MANTISSA_LEN + 1,
    localparam int IW         = $clog2(NUM_REQ * RSP_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*W-1:0]   req_a,
    input  logic [NUM_REQ*W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]     req_op,
    output logic                   add_valid,
    output logic [W-1:0]           add_a,
    output logic [W-1:0]           add_b,
    output logic                   add_op,
    output logic [TAG_W-1:0]       add_tag,
    input  logic                   res_valid,
    input  logic [TAG_W-1:0]       res_tag,
    input  logic [W-1:0]           res_data,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [NUM_REQ*W-1:0]   rsp_data,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [IW-1:0]          inflight,
    output logic                   err
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [CW-1:0]      credit_q [NUM_REQ];
    logic [CW-1:0]      cnt_q    [NUM_REQ];
    logic [PW-1:0]      wp_q     [NUM_REQ];
    logic [PW-1:0]      rp_q     [NUM_REQ];
    logic [W-1:0]       mem_q    [NUM_REQ][RSP_DEPTH];

    logic [TAG_W-1:0]   rr_q, rr_d;
    logic               add_valid_q;
    logic [W-1:0]       add_a_q, add_b_q;
    logic               add_op_q;
    logic [TAG_W-1:0]   add_tag_q;
    logic [IW-1:0]      inflight_q;
    logic               err_q;

    logic [NUM_REQ-1:0] elig, gnt, pop, wr_en, tag_hit, full;
    logic               gnt_any, tag_ok, err_set;
    logic [TAG_W-1:0]   win;
    logic [TAG_W:0]     scan;
    logic [W-1:0]       sel_a, sel_b;
    logic               sel_op;

    // Eligibility, FIFO status and result tag decode.
    always_comb begin
        elig    = '0;
        pop     = '0;
        full    = '0;
        tag_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]    = req_valid[i] && (credit_q[i] != '0);
            rsp_valid[i] = (cnt_q[i] != '0);
            full[i]    = (cnt_q[i] == DEPTH_C);
            tag_hit[i] = (res_tag == TAG_W'(i));
        end
        pop    = rsp_valid & rsp_ready;
        tag_ok = |tag_hit;
    end

    // Round-robin scan starting at rr_q; first eligible requester wins.
    always_comb begin
        gnt_any = 1'b0;
        win     = '0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_q} + (TAG_W+1)'(k);
            if (scan >= (TAG_W+1)'(NUM_REQ)) begin
                scan = scan - (TAG_W+1)'(NUM_REQ);
            end
            if (!gnt_any && elig[scan[TAG_W-1:0]]) begin
                gnt_any = 1'b1;
                win     = scan[TAG_W-1:0];
            end
        end
    end

    // Grants are suppressed while reset is asserted so req_ready reads 0 during reset.
    always_comb begin
        gnt    = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        if (gnt_any && rst_n) begin
            gnt = NUM_REQ'(1) << win;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i];
            end
        end
        if (!gnt_any) begin
            rr_d = rr_q;
        end else if (win == TAG_W'(NUM_REQ - 1)) begin
            rr_d = '0;
        end else begin
            rr_d = win + TAG_W'(1);
        end
    end

    // A result is only accepted for a valid tag, a non-full FIFO, and while something is outstanding.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_en[i] = res_valid && tag_hit[i] && !full[i] && (inflight_q != '0);
        end
        err_set = res_valid && (!tag_ok || (inflight_q == '0) || (|(tag_hit & full)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q        <= '0;
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_op_q    <= 1'b0;
            add_tag_q   <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                credit_q[i] <= DEPTH_C;
                cnt_q[i]    <= '0;
                wp_q[i]     <= '0;
                rp_q[i]     <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            add_valid_q <= gnt_any;
            if (gnt_any) begin
                add_a_q   <= sel_a;
                add_b_q   <= sel_b;
                add_op_q  <= sel_op;
                add_tag_q <= win;
            end
            // A result arriving with nothing outstanding is an error; the count must not underflow.
            case ({add_valid_q, res_valid})
                2'b10:   inflight_q <= inflight_q + IW'(1);
                2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - IW'(1);
                default: inflight_q <= inflight_q;
            endcase
            if (err_set) begin
                err_q <= 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({gnt[i], pop[i]})
                    2'b10:   credit_q[i] <= credit_q[i] - CW'(1);
                    2'b01:   credit_q[i] <= credit_q[i] + CW'(1);
                    default: credit_q[i] <= credit_q[i];
                endcase
                case ({wr_en[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
                    2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
                    default: cnt_q[i] <= cnt_q[i];
                endcase
                if (wr_en[i]) wp_q[i] <= wp_q[i] + PW'(1);
                if (pop[i])   rp_q[i] <= rp_q[i] + PW'(1);
            end
        end
    end

    // Storage needs no reset: rsp_data is masked while a FIFO is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_en[i]) begin
                mem_q[i][wp_q[i]] <= res_data;
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i]) begin
                rsp_data[i*W +: W] = mem_q[i][rp_q[i]];
            end
        end
    end

    assign req_ready = gnt;
    assign add_valid = add_valid_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_op    = add_op_q;
    assign add_tag   = add_tag_q;
    assign inflight  = inflight_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Purpose: directed self-checking bench for fp_add_arbiter with a 4-cycle adder model.
// Latency: model returns a result 4 cycles after add_valid; manual result injection available.
// Backpressure: rsp_ready driven per test to exercise credit exhaustion and simultaneous push/pop.

module tb_fp_add_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TW = 2;
    localparam int IW = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_ready, req_op;
    logic [NR*W-1:0] req_a, req_b;
    logic            add_valid, add_op;
    logic [W-1:0]    add_a, add_b;
    logic [TW-1:0]   add_tag;
    logic            res_valid;
    logic [TW-1:0]   res_tag;
    logic [W-1:0]    res_data;
    logic [NR-1:0]   rsp_valid, rsp_ready;
    logic [NR*W-1:0] rsp_data;
    logic [IW-1:0]   inflight;
    logic            err;

    logic            model_en;
    logic            man_valid;
    logic [TW-1:0]   man_tag;
    logic [W-1:0]    man_data;

    logic [3:0]      pv;
    logic [TW-1:0]   pt [4];
    logic [W-1:0]    pd [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_add_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .add_valid (add_valid),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_op    (add_op),
        .add_tag   (add_tag),
        .res_valid (res_valid),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .inflight  (inflight),
        .err       (err)
    );

    // Adder model: 1.0 + 2.0 = 3.0 is returned exactly; other operands return a ^ b as a marker value.
    function automatic logic [W-1:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 1'b0) return 32'h4040_0000;
        return a ^ b;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            for (int k = 0; k < 4; k++) begin
                pt[k] <= '0;
                pd[k] <= '0;
            end
        end else begin
            pv    <= {pv[2:0], add_valid};
            pt[0] <= add_tag;
            pd[0] <= fadd(add_a, add_b, add_op);
            for (int k = 1; k < 4; k++) begin
                pt[k] <= pt[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    assign res_valid = model_en ? pv[3] : man_valid;
    assign res_tag   = model_en ? pt[3] : man_tag;
    assign res_data  = model_en ? pd[3] : man_data;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int  peak;
    logic found;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
        model_en = 1'b1; man_valid = 1'b0; man_tag = '0; man_data = '0;

        // Reset defaults
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_add_valid", add_valid, 0);
        chk("rst_add_ab", {add_a, add_b, add_op, add_tag}, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);
        step();
        chk("rst_idle_add_valid", add_valid, 0);

        // Round-robin rotation with all four requesters active
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = 32'h1000_0000 + 32'(i);
            req_b[i*W +: W] = 32'h0000_0100 * 32'(i + 1);
        end
        rsp_ready = '1;
        req_valid = 4'hF;
        peak = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr_gnt%0d", c), req_ready, 4'b0001 << (c % 4));
            if (c > 0) begin
                chk($sformatf("rr_addv%0d", c), add_valid, 1);
                chk($sformatf("rr_tag%0d", c), add_tag, (c - 1) % 4);
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            step();
        end
        req_valid = '0;
        chk("rr_tag_last", add_tag, 3);
        for (int c = 0; c < 14; c++) begin
            if (int'(inflight) > peak) peak = int'(inflight);
            step();
        end
        chk("rr_peak_inflight", peak, 4);
        chk("rr_drain_inflight", inflight, 0);
        chk("rr_drain_rsp_valid", rsp_valid, 0);
        chk("rr_err", err, 0);

        // Credit exhaustion on requester 2
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("exh_gnt%0d", c), req_ready, (c < 4) ? 4'b0100 : 4'b0000);
            step();
        end
        for (int c = 0; c < 4; c++) step();
        chk("exh_rsp_valid", rsp_valid, 4'b0100);
        chk("exh_head", rsp_data[2*W +: W], 32'h1000_0002 ^ 32'h0000_0300);
        rsp_ready = 4'b1111;
        #1;
        chk("exh_pop_cycle_gnt", req_ready, 0);
        step();
        rsp_ready = 4'b1011;
        #1;
        chk("exh_regrant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < 14; c++) step();
        chk("exh_drain_inflight", inflight, 0);
        chk("exh_drain_rsp_valid", rsp_valid, 0);
        chk("exh_err", err, 0);

        // Routing: 1.0 + 2.0 from requester 1
        rsp_ready = '0;
        req_a[1*W +: W] = 32'h3F80_0000;
        req_b[1*W +: W] = 32'h4000_0000;
        req_op = '0;
        req_valid = 4'b0010;
        #1;
        chk("rt_gnt", req_ready, 4'b0010);
        step();
        req_valid = '0;
        chk("rt_add_valid", add_valid, 1);
        chk("rt_add_a", add_a, 32'h3F80_0000);
        chk("rt_add_b", add_b, 32'h4000_0000);
        chk("rt_add_op_tag", {add_op, add_tag}, {1'b0, 2'd1});
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (res_valid) found = 1'b1;
            else step();
        end
        chk("rt_res_seen", found, 1);
        chk("rt_rsp_before", rsp_valid, 0);
        step();
        chk("rt_rsp_valid", rsp_valid, 4'b0010);
        chk("rt_rsp_data", rsp_data[1*W +: W], 32'h4040_0000);
        step();
        chk("rt_rsp_hold", rsp_valid, 4'b0010);
        rsp_ready = 4'b0010;
        step();
        rsp_ready = '0;
        chk("rt_popped", rsp_valid, 0);

        // Simultaneous write and pop on FIFO 3, with a grant to 3 in the same cycle
        model_en = 1'b0;
        req_valid = 4'b1000;
        step(); step();
        req_valid = '0;
        step();
        chk("sim_inflight2", inflight, 2);
        man_valid = 1'b1; man_tag = 2'd3; man_data = 32'hAAAA_0001;
        step();
        man_valid = 1'b0;
        chk("sim_occ1_valid", rsp_valid, 4'b1000);
        chk("sim_occ1_head", rsp_data[3*W +: W], 32'hAAAA_0001);
        chk("sim_inflight1", inflight, 1);
        man_valid = 1'b1; man_data = 32'hBBBB_0002;
        rsp_ready = 4'b1000;
        req_valid = 4'b1000;
        #1;
        chk("sim_gnt", req_ready, 4'b1000);
        step();
        man_valid = 1'b0; rsp_ready = '0; req_valid = '0;
        chk("sim_valid", rsp_valid, 4'b1000);
        chk("sim_head_new", rsp_data[3*W +: W], 32'hBBBB_0002);
        req_valid = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("sim_credit%0d", c), req_ready, (c < 2) ? 4'b1000 : 4'b0000);
            step();
        end
        req_valid = '0;
        step(); step();
        chk("sim_inflight3", inflight, 3);
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;
        chk("sim_occ_was1", rsp_valid, 0);

        // Reset mid-operation clears tracking
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_add_valid", add_valid, 0);
        chk("mid_rst_err", err, 0);

        // Error: result with nothing in flight
        man_valid = 1'b1; man_tag = 2'd0; man_data = 32'h1234_5678;
        step();
        man_valid = 1'b0;
        chk("err_set", err, 1);
        chk("err_no_fifo", rsp_valid, 0);
        chk("err_inflight", inflight, 0);
        step(); step(); step();
        chk("err_sticky", err, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("err_cleared", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
